// File: rtl/instr_encoder.sv
// Packs decoded RISC-V I/S/B fields back into a 32-bit instruction word and tags
// each one with an auto-incrementing word address for the program-loader path.
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            err_count
);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_SRC   = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    logic                  accept;
    logic                  load;
    logic                  reject;
    logic                  fits_12;
    logic                  fits_13;
    logic [1:0]            chk_code;
    logic [31:0]           enc_instr;
    logic [ADDR_WIDTH-1:0] addr_cnt;

    // Single output register: a new request may enter only when the slot is free or draining.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (chk_code == ERR_NONE);
    assign reject   = accept && (chk_code != ERR_NONE);

    // An immediate fits when every bit above the field's sign bit copies that sign bit.
    assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);

    always_comb begin
        chk_code = ERR_NONE;
        case (imm_src)
            SRC_I, SRC_S: begin
                if (!fits_12) chk_code = ERR_RANGE;
            end
            SRC_B: begin
                if (!fits_13)    chk_code = ERR_RANGE;
                else if (imm[0]) chk_code = ERR_ALIGN;
            end
            default: chk_code = ERR_SRC;
        endcase
    end

    always_comb begin
        enc_instr = '0;
        case (imm_src)
            SRC_I:   enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
            SRC_S:   enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            SRC_B:   enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                                  imm[4:1], imm[11], opcode};
            default: enc_instr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= enc_instr;
            out_addr  <= addr_cnt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Rejected requests leave the counter alone so the next good instruction takes the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= BASE_ADDR;
        end else if (clear) begin
            addr_cnt <= BASE_ADDR;
        end else if (load) begin
            addr_cnt <= addr_cnt + ADDR_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_count <= '0;
        end else if (clear) begin
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_count <= '0;
        end else if (reject) begin
            err      <= 1'b1;
            err_code <= chk_code;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared each cycle against a behavioural reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  imm_src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;

    logic        in_ready, out_valid, err;
    logic [31:0] out_instr, out_addr;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    logic        in_ready4, out_valid4, err4;
    logic [31:0] out_instr4;
    logic [3:0]  out_addr4;
    logic [1:0]  err_code4;
    logic [7:0]  err_count4;

    int checks = 0;
    int failures = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_code(err_code),
        .err_count(err_count)
    );

    instr_encoder #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_addr(out_addr4), .err(err4), .err_code(err_code4),
        .err_count(err_count4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] classify(input logic [1:0] src, input logic [31:0] iv);
        int s;
        s = $signed(iv);
        if (src == 2'd3) return 2'd3;
        if (src != 2'd2) return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
        if (s < -4096 || s > 4095) return 2'd1;
        if (s % 2 != 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] encodeRef(input logic [1:0] src, input logic [6:0] op,
                                              input logic [4:0] rdv, input logic [4:0] r1,
                                              input logic [4:0] r2, input logic [2:0] f3,
                                              input logic [31:0] iv);
        logic [31:0] base;
        base = (32'(r1) << 15) | (32'(f3) << 12) | 32'(op);
        case (src)
            2'd0:    return base | ((iv & 32'hFFF) << 20) | (32'(rdv) << 7);
            2'd1:    return base | (((iv >> 5) & 32'h7F) << 25) | (32'(r2) << 20)
                                 | ((iv & 32'h1F) << 7);
            default: return base | (((iv >> 12) & 32'h1) << 31) | (((iv >> 5) & 32'h3F) << 25)
                                 | (32'(r2) << 20) | (((iv >> 1) & 32'hF) << 8)
                                 | (((iv >> 11) & 32'h1) << 7);
        endcase
    endfunction

    // Decoder-side view of the immediate, used for the round-trip check.
    function automatic logic [31:0] extractImm(input logic [1:0] src, input logic [31:0] ins);
        case (src)
            2'd0:    return {{20{ins[31]}}, ins[31:20]};
            2'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            default: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        endcase
    endfunction

    logic        mValid;
    logic [31:0] mInstr, mAddr, mCounter, mImm;
    logic [1:0]  mSrc, mCode, mChk;
    logic        mErr, mRdy;
    int          mCount;

    assign mRdy = !clear && (!mValid || out_ready);
    assign mChk = classify(imm_src, imm);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid <= 1'b0; mInstr <= '0; mAddr <= '0; mCounter <= '0;
            mImm <= '0; mSrc <= '0; mErr <= 1'b0; mCode <= '0; mCount <= 0;
        end else begin
            if (clear) begin
                mCounter <= '0; mErr <= 1'b0; mCode <= '0; mCount <= 0;
            end
            if (in_valid && mRdy && mChk == 2'd0) begin
                mValid   <= 1'b1;
                mInstr   <= encodeRef(imm_src, opcode, rd, rs1, rs2, funct3, imm);
                mAddr    <= mCounter;
                mCounter <= mCounter + 32'd4;
                mImm     <= imm;
                mSrc     <= imm_src;
            end else begin
                if (mValid && out_ready) mValid <= 1'b0;
                if (in_valid && mRdy) begin
                    mErr  <= 1'b1;
                    mCode <= mChk;
                    if (mCount < 255) mCount <= mCount + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("mon_valid", 32'(out_valid), 32'(mValid));
            checkOutput("mon_ready", 32'(in_ready), 32'(mRdy));
            checkOutput("mon_err", 32'(err), 32'(mErr));
            checkOutput("mon_err_code", 32'(err_code), 32'(mCode));
            checkOutput("mon_err_count", 32'(err_count), 32'(mCount));
            checkOutput("mon_valid4", 32'(out_valid4), 32'(mValid));
            if (mValid) begin
                checkOutput("mon_instr", out_instr, mInstr);
                checkOutput("mon_addr", out_addr, mAddr);
                checkOutput("mon_roundtrip", extractImm(mSrc, out_instr), mImm);
                checkOutput("mon_addr4", 32'(out_addr4), 32'(mAddr[3:0]));
            end
        end
    end

    task automatic setReq(input logic [1:0] src, input logic [6:0] op, input logic [4:0] rdv,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                          input logic [31:0] iv);
        imm_src = src; opcode = op; rd = rdv; rs1 = r1; rs2 = r2; funct3 = f3; imm = iv;
    endtask

    task automatic applyStimulus(input logic [1:0] src, input logic [6:0] op, input logic [4:0] rdv,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                                 input logic [31:0] iv);
        setReq(src, op, rdv, r1, r2, f3, iv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    int bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097, 4096, 1};

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);
        checkOutput("rst_addr", out_addr, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        applyStimulus(2'd0, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_instr", out_instr, 32'hFFF00093);
        checkOutput("t1_addr", out_addr, 32'h0);
        idle(1);
        checkOutput("t1_pulse", 32'(out_valid), 32'd0);

        applyStimulus(2'd1, OP_S, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8);
        checkOutput("t2_s_instr", out_instr, 32'h0021A423);
        checkOutput("t2_s_addr", out_addr, 32'h4);
        applyStimulus(2'd2, OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
        checkOutput("t2_b_instr", out_instr, 32'hFE208EE3);
        checkOutput("t2_b_addr", out_addr, 32'h8);
        idle(1);

        applyStimulus(2'd0, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        checkOutput("t3_range_err", 32'(err), 32'd1);
        checkOutput("t3_range_code", 32'(err_code), 32'd1);
        checkOutput("t3_range_valid", 32'(out_valid), 32'd0);
        applyStimulus(2'd2, OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        checkOutput("t3_align_code", 32'(err_code), 32'd2);
        checkOutput("t3_align_valid", 32'(out_valid), 32'd0);
        applyStimulus(2'd3, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
        checkOutput("t3_src_code", 32'(err_code), 32'd3);
        checkOutput("t3_src_valid", 32'(out_valid), 32'd0);
        checkOutput("t3_count", 32'(err_count), 32'd3);
        applyStimulus(2'd0, OP_I, 5'd5, 5'd6, 5'd0, 3'd0, 32'd100);
        checkOutput("t3_next_addr", out_addr, 32'hC);

        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        checkOutput("t4_cleared_count", 32'(err_count), 32'd0);
        out_ready = 1'b0;
        applyStimulus(2'd0, OP_I, 5'd2, 5'd3, 5'd0, 3'd0, 32'd5);
        setReq(2'd1, OP_S, 5'd0, 5'd4, 5'd5, 3'b010, 32'd12);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_stall_ready", 32'(in_ready), 32'd0);
            checkOutput("t4_stall_valid", 32'(out_valid), 32'd1);
            checkOutput("t4_stall_instr", out_instr, 32'h00518113);
            checkOutput("t4_stall_addr", out_addr, 32'h0);
            idle(1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("t4_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("t4_second_instr", out_instr, 32'h00522623);
        checkOutput("t4_second_addr", out_addr, 32'h4);
        idle(1);
        checkOutput("t4_drained", 32'(out_valid), 32'd0);

        applyStimulus(2'd3, OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        checkOutput("t5_err_set", 32'(err), 32'd1);
        out_ready = 1'b0;
        applyStimulus(2'd0, OP_I, 5'd7, 5'd1, 5'd0, 3'd0, 32'hFFFFFFFF);
        checkOutput("t5_pending_addr", out_addr, 32'h8);
        clear = 1'b1;
        setReq(2'd0, OP_I, 5'd9, 5'd1, 5'd0, 3'd0, 32'd1);
        in_valid = 1'b1;
        #1;
        checkOutput("t5_clear_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        checkOutput("t5_clear_err", 32'(err), 32'd0);
        checkOutput("t5_clear_count", 32'(err_count), 32'd0);
        checkOutput("t5_keep_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_keep_instr", out_instr, 32'hFFF08393);
        checkOutput("t5_keep_addr", out_addr, 32'h8);
        out_ready = 1'b1;
        idle(1);
        checkOutput("t5_drained", 32'(out_valid), 32'd0);
        applyStimulus(2'd0, OP_I, 5'd9, 5'd1, 5'd0, 3'd0, 32'd1);
        checkOutput("t5_base_addr", out_addr, 32'h0);

        out_ready = 1'b0;
        applyStimulus(2'd0, OP_I, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1);
        checkOutput("t5_stall_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_addr", out_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 32'(i));
            checkOutput("t6_valid4", 32'(out_valid4), 32'd1);
            checkOutput("t6_addr4", 32'(out_addr4), 32'((i * 4) % 16));
        end

        setReq(2'd3, OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("t6_sat_count", 32'(err_count), 32'd255);
        checkOutput("t6_sat_count4", 32'(err_count4), 32'd255);
        checkOutput("t6_sat_code", 32'(err_code), 32'd3);

        for (int c = 0; c < 600; c++) begin
            int mode;
            logic [31:0] iv;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       iv = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       iv = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       iv = $urandom;
                default: iv = 32'(bnd[$urandom_range(0, 9)]);
            endcase
            setReq(2'($urandom_range(0, 3)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), iv);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 29) == 0);
            idle(1);
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the core's immediate extraction. Takes decoded fields (opcode, registers, funct3, a 32-bit signed immediate and the ImmSrc format code) and packs them into a 32-bit RISC-V I/S/B instruction. Each output carries an auto-incrementing word address. Used by the program-loader/self-test path to stream generated instructions into instruction memory, with a valid/ready handshake on both sides.

Parameters:
ADDR_WIDTH, 32, width of out_addr; the address counter wraps modulo 2^ADDR_WIDTH.
BASE_ADDR, 0, value loaded into the address counter on reset and clear; must be 4-byte aligned.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous clear of address counter and error state
in_valid  input  1  request present
in_ready  output  1  request accepted when in_valid && in_ready
imm_src  input  2  00 I-type, 01 S-type, 10 B-type, 11 reserved (same codes as the core's ImmSrc)
opcode  input  7  instr[6:0]
rd  input  5  destination register, I-type only
rs1  input  5  source register 1
rs2  input  5  source register 2, S/B only
funct3  input  3  instr[14:12]
imm  input  32  signed immediate (byte offset for B)
out_valid  output  1  encoded instruction present
out_ready  input  1  downstream accepts when out_valid && out_ready
out_instr  output  32  encoded instruction
out_addr  output  ADDR_WIDTH  address assigned to out_instr
err  output  1  sticky: at least one request rejected since reset/clear
err_code  output  2  code of most recent rejection: 01 range, 10 misaligned, 11 reserved imm_src
err_count  output  8  rejected requests, saturates at 255

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_addr=0, err=0, err_code=00, err_count=0; address counter = BASE_ADDR. Deassertion is synchronous to clk.
- in_ready = !clear && (!out_valid || out_ready), combinational. There is a single output register with no input-side buffering.
- Latency: 1 cycle. A request accepted at edge N appears on out_instr/out_addr with out_valid=1 after edge N.
- Output hold: while out_valid && !out_ready, out_instr and out_addr stay stable.
- out_valid clears on a handshake edge with no new valid accept. Back-to-back accept and drain sustains 1 instruction/cycle.
- Validity check on accept, in priority order:
  - imm_src=11 -> code 11.
  - I/S: imm[31:11] not all equal -> code 01.
  - B: imm[31:12] not all equal -> code 01.
  - B: imm[0]=1 -> code 10.
- Rejected request:
  - Consumed (handshake completes) but produces no output.
  - Address counter unchanged.
  - err<=1, err_code<=code, err_count<=min(err_count+1, 255).
  - out_valid/out_instr are not disturbed; a pending output still drains normally.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - Unused inputs (rd for S/B, rs2 for I) are ignored.
- Addressing: a valid accept loads out_addr <= counter and counter <= counter+4, wrapping modulo 2^ADDR_WIDTH with no flag.
- clear=1:
  - counter <= BASE_ADDR; err, err_code, err_count <= 0.
  - in_ready forced 0, so no accept that cycle.
  - A pending out_valid output is kept and still drains; its out_addr is unchanged.
- Round-trip property: extracting the immediate from out_instr with the same imm_src yields exactly imm for every accepted request.
- rst asserted mid-transfer drops any pending output immediately (async). The downstream must not count it as delivered.

Test Plan:
1. I: opcode=0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> next cycle out_instr=0xFFF00093, out_addr=0x0, out_valid=1 for one cycle.
2. S: opcode=0100011, rs1=3, rs2=2, funct3=010, imm=8 -> out_instr=0x0021A423, out_addr=0x4. Then B: opcode=1100011, rs1=1, rs2=2, funct3=000, imm=0xFFFFFFFC -> out_instr=0xFE208EE3, out_addr=0x8.
3. Rejections:
   - I imm=2048 -> err=1, err_code=01.
   - B imm=3 -> err_code=10.
   - imm_src=11 -> err_code=11.
   - After all three: no out_valid pulse, err_count=3, and the next valid request gets the unchanged address.
4. Backpressure: hold out_ready=0 for 3 cycles with two back-to-back requests -> first output stable for 3 cycles, in_ready=0, second accepted on the release edge. Addresses 0x0 then 0x4, no loss or duplication.
5. clear with a pending output and err=1 -> in_ready=0 that cycle, pending output drains unchanged, err/err_count=0, next accepted output at BASE_ADDR. Separately, async rst mid-stall -> out_valid=0 immediately.
6. ADDR_WIDTH=4: 5 valid requests -> out_addr 0x0, 0x4, 0x8, 0xC, 0x0. Separately, 260 rejections -> err_count holds at 255.
